// File: rtl/ex_mem_stage.sv
// rtl/ex_mem_stage.sv - EX/MEM pipeline register with overflow trap and eret sequencing
module ex_mem_stage #(
   parameter logic [31:0] EXC_VECTOR = 32'h0000_0080,
   parameter logic [4:0]  OVF_CAUSE  = 5'd12
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        ex_valid,
   input  logic [31:0] ex_pc,
   input  logic [31:0] ex_alu_out,
   input  logic        ex_ovf,
   input  logic        ex_ovf_en,
   input  logic [31:0] ex_rt_data,
   input  logic [4:0]  ex_rd_addr,
   input  logic        ex_reg_we,
   input  logic        ex_mem_re,
   input  logic        ex_mem_we,
   input  logic        mem_stall,
   input  logic        eret,
   output logic        ex_ready,
   output logic        mem_valid,
   output logic [31:0] mem_pc,
   output logic [31:0] mem_alu_out,
   output logic [31:0] mem_rt_data,
   output logic [4:0]  mem_rd_addr,
   output logic        mem_reg_we,
   output logic        mem_mem_re,
   output logic        mem_mem_we,
   output logic        flush,
   output logic        redirect_valid,
   output logic [31:0] redirect_pc,
   output logic [31:0] epc,
   output logic [4:0]  cause,
   output logic        double_fault
);

   typedef enum logic [1:0] {RUN, TRAP, HANDLER, RETURN} state_e;

   state_e      state_q;
   logic        mem_valid_q, mem_reg_we_q, mem_mem_re_q, mem_mem_we_q;
   logic [31:0] mem_pc_q, mem_alu_out_q, mem_rt_data_q, epc_q;
   logic [4:0]  mem_rd_addr_q, cause_q;
   logic        double_fault_q;
   logic        xfer, ovf_trap, redirecting;

   assign ex_ready    = ((state_q == RUN) || (state_q == HANDLER)) && !mem_stall;
   assign xfer        = ex_valid && ex_ready;
   assign ovf_trap    = ex_ovf && ex_ovf_en;
   assign redirecting = (state_q == TRAP) || (state_q == RETURN);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= RUN;
         mem_valid_q    <= 1'b0;
         mem_pc_q       <= '0;
         mem_alu_out_q  <= '0;
         mem_rt_data_q  <= '0;
         mem_rd_addr_q  <= '0;
         mem_reg_we_q   <= 1'b0;
         mem_mem_re_q   <= 1'b0;
         mem_mem_we_q   <= 1'b0;
         epc_q          <= '0;
         cause_q        <= '0;
         double_fault_q <= 1'b0;
      end else begin
         // Redirect states are single-cycle regardless of stall.
         case (state_q)
            TRAP:    state_q <= HANDLER;
            RETURN:  state_q <= RUN;
            default: ;
         endcase
         if (xfer) begin
            mem_pc_q      <= ex_pc;
            mem_alu_out_q <= ex_alu_out;
            mem_rt_data_q <= ex_rt_data;
            mem_rd_addr_q <= ex_rd_addr;
            mem_valid_q   <= 1'b1;
            mem_reg_we_q  <= ex_reg_we;
            mem_mem_re_q  <= ex_mem_re;
            mem_mem_we_q  <= ex_mem_we;
            if ((state_q == HANDLER) && eret) begin
               mem_valid_q  <= 1'b0;
               mem_reg_we_q <= 1'b0;
               mem_mem_re_q <= 1'b0;
               mem_mem_we_q <= 1'b0;
               state_q      <= RETURN;
            end else if (ovf_trap) begin
               mem_valid_q  <= 1'b0;
               mem_reg_we_q <= 1'b0;
               mem_mem_re_q <= 1'b0;
               mem_mem_we_q <= 1'b0;
               // A fault inside the handler must not clobber the saved context.
               if (state_q == RUN) begin
                  epc_q   <= ex_pc;
                  cause_q <= OVF_CAUSE;
                  state_q <= TRAP;
               end else begin
                  double_fault_q <= 1'b1;
               end
            end
         end else if (!mem_stall) begin
            mem_valid_q <= 1'b0;
         end
      end
   end

   assign mem_valid      = mem_valid_q;
   assign mem_pc         = mem_pc_q;
   assign mem_alu_out    = mem_alu_out_q;
   assign mem_rt_data    = mem_rt_data_q;
   assign mem_rd_addr    = mem_rd_addr_q;
   assign mem_reg_we     = mem_reg_we_q;
   assign mem_mem_re     = mem_mem_re_q;
   assign mem_mem_we     = mem_mem_we_q;
   assign flush          = redirecting;
   assign redirect_valid = redirecting;
   assign redirect_pc    = (state_q == TRAP)   ? EXC_VECTOR :
                           (state_q == RETURN) ? epc_q      : '0;
   assign epc            = epc_q;
   assign cause          = cause_q;
   assign double_fault   = double_fault_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
// tb/tb_ex_mem_stage.sv - directed self-checking bench for ex_mem_stage
module tb_ex_mem_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        ex_valid, ex_ovf, ex_ovf_en, ex_reg_we, ex_mem_re, ex_mem_we;
   logic        mem_stall, eret;
   logic [31:0] ex_pc, ex_alu_out, ex_rt_data;
   logic [4:0]  ex_rd_addr;
   logic        ex_ready, mem_valid, mem_reg_we, mem_mem_re, mem_mem_we;
   logic [31:0] mem_pc, mem_alu_out, mem_rt_data;
   logic [4:0]  mem_rd_addr;
   logic        flush, redirect_valid, double_fault;
   logic [31:0] redirect_pc, epc;
   logic [4:0]  cause;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   ex_mem_stage dut (
      .clk(clk), .rst_n(rst_n),
      .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_alu_out(ex_alu_out),
      .ex_ovf(ex_ovf), .ex_ovf_en(ex_ovf_en), .ex_rt_data(ex_rt_data),
      .ex_rd_addr(ex_rd_addr), .ex_reg_we(ex_reg_we), .ex_mem_re(ex_mem_re),
      .ex_mem_we(ex_mem_we), .mem_stall(mem_stall), .eret(eret),
      .ex_ready(ex_ready), .mem_valid(mem_valid), .mem_pc(mem_pc),
      .mem_alu_out(mem_alu_out), .mem_rt_data(mem_rt_data),
      .mem_rd_addr(mem_rd_addr), .mem_reg_we(mem_reg_we),
      .mem_mem_re(mem_mem_re), .mem_mem_we(mem_mem_we),
      .flush(flush), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .epc(epc), .cause(cause), .double_fault(double_fault)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] alu,
                        input logic ovf, input logic ovf_en, input logic er);
      ex_valid   = v;
      ex_pc      = pc;
      ex_alu_out = alu;
      ex_ovf     = ovf;
      ex_ovf_en  = ovf_en;
      eret       = er;
   endtask

   initial begin
      rst_n = 1'b0; mem_stall = 1'b0;
      ex_rt_data = 32'h0000_0055; ex_rd_addr = 5'd3;
      ex_reg_we = 1'b1; ex_mem_re = 1'b0; ex_mem_we = 1'b1;
      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
      step();
      chk("rst_mem_valid", 32'(mem_valid), 32'd0);
      chk("rst_mem_pc", mem_pc, 32'd0);
      chk("rst_flush", 32'(flush), 32'd0);
      chk("rst_epc", epc, 32'd0);
      chk("rst_ex_ready", 32'(ex_ready), 32'd1);
      rst_n = 1'b1;
      step();

      // addu wrapping: overflow flag without enable passes through
      drive(1'b1, 32'h100, 32'h8000_0000, 1'b1, 1'b0, 1'b0);
      step();
      chk("addu_valid", 32'(mem_valid), 32'd1);
      chk("addu_alu", mem_alu_out, 32'h8000_0000);
      chk("addu_reg_we", 32'(mem_reg_we), 32'd1);
      chk("addu_mem_we", 32'(mem_mem_we), 32'd1);
      chk("addu_rd", 32'(mem_rd_addr), 32'd3);
      chk("addu_rt", mem_rt_data, 32'h55);
      chk("addu_flush", 32'(flush), 32'd0);

      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
      step();
      chk("bubble_valid", 32'(mem_valid), 32'd0);
      chk("bubble_alu_hold", mem_alu_out, 32'h8000_0000);

      // stall for three cycles
      drive(1'b1, 32'h200, 32'h1234, 1'b0, 1'b0, 1'b0);
      mem_stall = 1'b1;
      #1;
      chk("stall_ready", 32'(ex_ready), 32'd0);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("stall_valid", 32'(mem_valid), 32'd0);
         chk("stall_alu", mem_alu_out, 32'h8000_0000);
         chk("stall_pc", mem_pc, 32'h100);
      end
      mem_stall = 1'b0;
      #1;
      chk("unstall_ready", 32'(ex_ready), 32'd1);
      step();
      chk("unstall_valid", 32'(mem_valid), 32'd1);
      chk("unstall_pc", mem_pc, 32'h200);
      chk("unstall_alu", mem_alu_out, 32'h1234);

      // eret in RUN is an ordinary instruction
      drive(1'b1, 32'h300, 32'h5, 1'b0, 1'b0, 1'b1);
      step();
      chk("run_eret_valid", 32'(mem_valid), 32'd1);
      chk("run_eret_pc", mem_pc, 32'h300);
      chk("run_eret_redir", 32'(redirect_valid), 32'd0);
      chk("run_eret_rpc", redirect_pc, 32'd0);

      // overflow trap
      drive(1'b1, 32'h400, 32'h8000_0000, 1'b1, 1'b1, 1'b0);
      step();
      chk("trap_valid", 32'(mem_valid), 32'd0);
      chk("trap_reg_we", 32'(mem_reg_we), 32'd0);
      chk("trap_mem_we", 32'(mem_mem_we), 32'd0);
      chk("trap_epc", epc, 32'h400);
      chk("trap_cause", 32'(cause), 32'd12);
      chk("trap_flush", 32'(flush), 32'd1);
      chk("trap_redir", 32'(redirect_valid), 32'd1);
      chk("trap_rpc", redirect_pc, 32'h80);
      chk("trap_ready", 32'(ex_ready), 32'd0);

      // TRAP leaves after one cycle even under stall
      drive(1'b1, 32'h404, 32'h9, 1'b0, 1'b0, 1'b0);
      mem_stall = 1'b1;
      step();
      chk("hnd_stall_flush", 32'(flush), 32'd0);
      chk("hnd_stall_ready", 32'(ex_ready), 32'd0);
      chk("hnd_stall_valid", 32'(mem_valid), 32'd0);
      mem_stall = 1'b0;

      drive(1'b1, 32'h80, 32'h77, 1'b0, 1'b0, 1'b0);
      step();
      chk("hnd_valid", 32'(mem_valid), 32'd1);
      chk("hnd_pc", mem_pc, 32'h80);
      chk("hnd_flush", 32'(flush), 32'd0);
      chk("hnd_epc", epc, 32'h400);

      // overflow inside the handler
      drive(1'b1, 32'h84, 32'h8000_0000, 1'b1, 1'b1, 1'b0);
      step();
      chk("df_valid", 32'(mem_valid), 32'd0);
      chk("df_reg_we", 32'(mem_reg_we), 32'd0);
      chk("df_flag", 32'(double_fault), 32'd1);
      chk("df_epc", epc, 32'h400);
      chk("df_cause", 32'(cause), 32'd12);
      chk("df_flush", 32'(flush), 32'd0);
      chk("df_ready", 32'(ex_ready), 32'd1);

      // eret together with overflow: eret wins
      drive(1'b1, 32'h88, 32'h8000_0000, 1'b1, 1'b1, 1'b1);
      step();
      chk("ret_valid", 32'(mem_valid), 32'd0);
      chk("ret_flush", 32'(flush), 32'd1);
      chk("ret_redir", 32'(redirect_valid), 32'd1);
      chk("ret_rpc", redirect_pc, 32'h400);
      chk("ret_ready", 32'(ex_ready), 32'd0);
      chk("ret_epc", epc, 32'h400);

      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
      step();
      chk("back_run_flush", 32'(flush), 32'd0);
      chk("back_run_rpc", redirect_pc, 32'd0);
      chk("back_run_ready", 32'(ex_ready), 32'd1);
      chk("back_run_df", 32'(double_fault), 32'd1);

      // trap again, then reset during TRAP
      drive(1'b1, 32'h500, 32'h8000_0000, 1'b1, 1'b1, 1'b0);
      step();
      chk("trap2_epc", epc, 32'h500);
      chk("trap2_flush", 32'(flush), 32'd1);
      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
      rst_n = 1'b0;
      #1;
      chk("rstT_flush", 32'(flush), 32'd0);
      chk("rstT_redir", 32'(redirect_valid), 32'd0);
      chk("rstT_rpc", redirect_pc, 32'd0);
      chk("rstT_epc", epc, 32'd0);
      chk("rstT_cause", 32'(cause), 32'd0);
      chk("rstT_df", 32'(double_fault), 32'd0);
      chk("rstT_alu", mem_alu_out, 32'd0);
      #2;
      rst_n = 1'b1;
      step();
      chk("post_rst_flush", 32'(flush), 32'd0);
      chk("post_rst_ready", 32'(ex_ready), 32'd1);
      mem_stall = 1'b1;
      #1;
      chk("post_rst_stall_ready", 32'(ex_ready), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
